// File: rtl/gpu_pkg.sv
// gpu_pkg: framebuffer geometry, VGA timing defaults and pixel formats shared by scanout and rasterizer
package gpu_pkg;
  localparam int FB_W = 640;
  localparam int FB_H = 480;
  localparam int FB_ADDR_W = 19;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic sof;
  } flags_t;
  localparam flags_t FLAGS_RST = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, sof: 1'b0};
endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port and bank-swap handshake between scanout and rasterizer
interface vga_scanout_if;
  logic                           rd_en;
  logic [gpu_pkg::FB_ADDR_W-1:0]  rd_addr;
  logic [7:0]                     rd_data;
  logic                           disp_bank;
  logic                           swap_req;
  logic                           swap_ack;
  modport master (output rd_en, rd_addr, disp_bank, swap_ack, input rd_data, swap_req);
  modport slave  (input rd_en, rd_addr, disp_bank, swap_ack, output rd_data, swap_req);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters with visible flag, raw syncs, frame start and swap-point strobe
module vga_timing import gpu_pkg::*; #(
  parameter int H_VIS  = FB_W,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_VIS  = FB_H,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D
) (
  input  logic   clk,
  input  logic   rst_n,
  output flags_t flags_o,
  output logic   swap_pt_o
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_wrap;
  always_comb begin
    h_wrap = h_q == HW'(H_TOT - 1);
    h_d = h_wrap ? '0 : h_q + 1'b1;
    v_d = !h_wrap ? v_q : (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  always_comb begin
    flags_o.vis  = h_q < HW'(H_VIS) && v_q < VW'(V_VIS);
    flags_o.hs_n = !(h_q >= HW'(H_VIS + H_FP) && h_q < HW'(H_VIS + H_FP + H_SYNC));
    flags_o.vs_n = !(v_q >= VW'(V_VIS + V_FP) && v_q < VW'(V_VIS + V_FP + V_SYNC));
    flags_o.sof  = h_q == '0 && v_q == '0;
    swap_pt_o    = h_q == '0 && v_q == VW'(V_VIS);
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer scanout with address sweep, front/back bank swap and pin-aligned RGB332/sync pipeline
module vga_scanout import gpu_pkg::*; #(
  parameter int H_VIS  = FB_W,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_VIS  = FB_H,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_scanout_if.master fb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic [2:0]  vga_r_o,
  output logic [2:0]  vga_g_o,
  output logic [1:0]  vga_b_o
);
  flags_t cur;
  logic   swap_pt;
  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags_o   (cur),
    .swap_pt_o (swap_pt)
  );
  logic                 rd_en_q;
  logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                 bank_q, bank_d, ack_q, ack_d;
  flags_t [RD_LAT:0]    pipe_q;
  flags_t               pin_q, pin_d;
  rgb332_t              rgb_q, rgb_d;
  always_comb begin
    rd_addr_d = cur.sof ? '0 : cur.vis ? rd_addr_q + 1'b1 : rd_addr_q;
    ack_d     = swap_pt && fb.swap_req;
    bank_d    = bank_q ^ ack_d;
    pin_d     = pipe_q[RD_LAT];
    rgb_d     = pin_d.vis ? rgb332_t'(fb.rd_data) : '0;
  end
  // Flag pipe tracks rd_data so syncs, de and colours land on the same pin edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      bank_q    <= 1'b0;
      ack_q     <= 1'b0;
      pipe_q    <= {(RD_LAT + 1){FLAGS_RST}};
      pin_q     <= FLAGS_RST;
      rgb_q     <= '0;
    end else begin
      rd_en_q   <= cur.vis;
      rd_addr_q <= rd_addr_d;
      bank_q    <= bank_d;
      ack_q     <= ack_d;
      pipe_q[0] <= cur;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      pin_q     <= pin_d;
      rgb_q     <= rgb_d;
    end
  assign fb.rd_en      = rd_en_q;
  assign fb.rd_addr    = rd_addr_q;
  assign fb.disp_bank  = bank_q;
  assign fb.swap_ack   = ack_q;
  assign de_o          = pin_q.vis;
  assign hsync_o       = pin_q.hs_n;
  assign vsync_o       = pin_q.vs_n;
  assign frame_start_o = pin_q.sof;
  assign {vga_r_o, vga_g_o, vga_b_o} = rgb_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks scanout against a position-based raster model on a shrunken timing
module tb_vga_scanout;
  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic hsync, vsync, de, fs;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  vga_scanout_if fb();

  vga_scanout #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RD_LAT(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fb            (fb.master),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .de_o          (de),
    .frame_start_o (fs),
    .vga_r_o       (vga_r),
    .vga_g_o       (vga_g),
    .vga_b_o       (vga_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic mode_e3;
  logic [7:0] salt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic vis_f(int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return h < HV && v < VV;
  endfunction
  function automatic logic hs_f(int p);
    int h;
    h = p % HT;
    return h >= HV + HF && h < HV + HF + HS;
  endfunction
  function automatic logic vs_f(int p);
    int v;
    v = (p / HT) % VT;
    return v >= VV + VF && v < VV + VF + VS;
  endfunction
  // Address of the pixel at p, or of the last visible pixel before it in the frame
  function automatic int addr_f(int p);
    int h, v, vb;
    h = p % HT;
    v = (p / HT) % VT;
    vb = (v < VV ? v : VV) * HV + (v < VV ? (h < HV ? h : HV) : 0);
    return vis_f(p) ? vb : vb - 1;
  endfunction
  function automatic logic [7:0] memf(int addr, logic bank);
    logic [7:0] a;
    a = addr[7:0];
    return mode_e3 ? 8'hE3 : ((a * 8'd37) ^ salt ^ (bank ? 8'hA5 : 8'h00));
  endfunction

  always @(posedge clk)
    if (fb.rd_en) fb.rd_data <= memf(int'(fb.rd_addr), fb.disp_bank);

  // n = edges since reset release; the raster position sampled at an edge is the old n
  int n;
  logic mbank, mack;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n <= 0;
      mbank <= 1'b0;
      mack <= 1'b0;
    end else begin
      n <= n + 1;
      mack <= (n % FT == VV * HT) && fb.swap_req;
      if ((n % FT == VV * HT) && fb.swap_req) mbank <= ~mbank;
    end

  always @(negedge clk) begin : cmp
    int p, q;
    p = n - 1;
    q = n - 3;
    check("rd_en", fb.rd_en, n >= 1 && vis_f(p));
    check("rd_addr", fb.rd_addr, n >= 1 ? addr_f(p) : 0);
    check("disp_bank", fb.disp_bank, mbank);
    check("swap_ack", fb.swap_ack, mack);
    check("de", de, n >= 3 && vis_f(q));
    check("hsync", hsync, !(n >= 3 && hs_f(q)));
    check("vsync", vsync, !(n >= 3 && vs_f(q)));
    check("frame_start", fs, n >= 3 && q % FT == 0);
    check("rgb", {vga_r, vga_g, vga_b}, (n >= 3 && vis_f(q)) ? memf(addr_f(q), mbank) : 0);
  end

  task automatic do_reset(logic e3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    mode_e3 = e3;
    salt = 8'($urandom);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first_hs, first_de, first_fs, reads, hs_low, vs_low, i;
    rst_n = 1'b0;
    fb.swap_req = 1'b0;
    fb.rd_data = 8'h00;
    mode_e3 = 1'b1;
    salt = 8'h00;
    first_hs = 0; first_de = 0; first_fs = 0; reads = 0; hs_low = 0; vs_low = 0;
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= FT; k++) begin
      @(negedge clk);
      if (fb.rd_en) reads++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (!hsync && first_hs == 0) first_hs = k;
      if (fs && first_fs == 0) first_fs = k;
      if (de && first_de == 0) begin
        first_de = k;
        check("e3_r", vga_r, 7);
        check("e3_g", vga_g, 0);
        check("e3_b", vga_b, 3);
      end
    end
    check("hsync_first_fall", first_hs, HV + HF + 3);
    check("first_de", first_de, 3);
    check("first_frame_start", first_fs, 3);
    check("reads_per_frame", reads, HV * VV);
    check("hsync_low_cycles", hs_low, HS * VT);
    check("vsync_low_cycles", vs_low, VS * HT);

    for (i = 0; i < 2 * FT && (n % FT) / HT != 3; i++) @(negedge clk);
    check("reach_line3", (n % FT) / HT, 3);
    fb.swap_req = 1'b1;
    for (i = 0; i < 2 * FT && !fb.swap_ack; i++) @(negedge clk);
    check("swap_ack_seen", fb.swap_ack, 1);
    check("swap_ack_pos", n % FT, VV * HT + 1);
    check("swap_bank", fb.disp_bank, 1);
    fb.swap_req = 1'b0;
    repeat (FT) @(negedge clk);

    do_reset(1'b0);
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) fb.swap_req = ~fb.swap_req;
      if ($urandom_range(0, 1999) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    fb.swap_req = 1'b0;
    for (i = 0; i < 2 * FT && n % FT != 6 * HT + 10; i++) @(negedge clk);
    check("reach_mid", n % FT, 6 * HT + 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rd_en", fb.rd_en, 0);
    check("mid_rd_addr", fb.rd_addr, 0);
    check("mid_hsync", hsync, 1);
    check("mid_vsync", vsync, 1);
    check("mid_de", de, 0);
    check("mid_rgb", {vga_r, vga_g, vga_b}, 0);
    check("mid_bank", fb.disp_bank, 0);
    check("mid_ack", fb.swap_ack, 0);
    check("mid_fs", fs, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) check("restart_addr", fb.rd_addr, 0);
      if (k == 1) check("restart_rd_en", fb.rd_en, 1);
      if (k == 3) check("restart_fs", fs, 1);
    end
    repeat (FT) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
